lm_arbiter: RTL and testbench
=============================

# lm_arbiter

Shares the LED manager FIFO write port between several LED event sources: error, data and actualization. It accepts a request/acknowledge handshake from each source and picks one winner per arbitration round, round-robin, with an optional fixed error priority. It writes the winner's word into the LED FIFO, respecting the FIFO full flag. It sits upstream of the LED FIFO, whose read side feeds the LED decoder.

## Interface
- `WIDTH`, default `WIDTH_LEDS` (8): LED word width.
- `N_SRC`, default 3: number of requesters. Index 0 is the error source, 1 is data, 2 is actualization.
- `STALL_MAX`, default 1024: consecutive blocked cycles before `stall` is raised.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `req`, input, `N_SRC`: per-source request. The source holds it high until acked.
- `src_data`, input, `N_SRC*WIDTH`: per-source word. Source k occupies bits [k*WIDTH +: WIDTH]. It must be stable while `req[k]` is high.
- `fifo_full`, input, 1: LED FIFO full flag.
- `ack`, output, `N_SRC`: one-hot, one-cycle pulse to the winning source.
- `wr_en`, output, 1: FIFO write strobe, one cycle long.
- `wr_data`, output, `WIDTH`: FIFO write word.
- `stall`, output, 1: sticky flag; the FIFO blocked pending requests for `STALL_MAX` cycles.

## Operation
- The FSM has two states, IDLE and GRANT.
- IDLE to GRANT happens when `|req` is high and `fifo_full` is low. In that cycle the block selects winner k, latches `src_data[k]` into `wr_data` and latches k.
- GRANT always returns to IDLE. In GRANT, `wr_en` is 1 and `ack[k]` is 1.
- In IDLE, `wr_en` and `ack` are 0. `wr_data` holds its last value.
- Round-robin search:
  - The pointer `last` holds the index of the last winner.
  - The search starts at (`last`+1) mod `N_SRC` and takes the first asserted `req` in ascending wrapped order.
  - `last` updates to k on entry to GRANT.
  - Index `N_SRC`-1 wraps to 0.
- A source that keeps `req` high after its ack re-enters arbitration as a new request.
- Requests that arrive while the FSM is in GRANT are held by the source and considered in the next IDLE.
- Stall counter:
  - It increments in each IDLE cycle with `|req` and `fifo_full` both high.
  - It clears to 0 on any grant, and in any IDLE cycle where `|req` is 0.
  - It saturates at `STALL_MAX`. Reaching `STALL_MAX` sets `stall`.
  - `stall` clears only on reset.
- The counter is wide enough to hold `STALL_MAX`.

## Timing
- Reset values: state IDLE, `last`=`N_SRC`-1 (so source 0 wins first), `wr_en`=0, `ack`=0, `wr_data`=0, `stall`=0, stall counter 0.
- Latency: request sampled in IDLE at cycle t gives `wr_en` and `ack` at cycle t+1. The next arbitration happens at t+2.
- Peak throughput is one write every 2 cycles.
- The source drops or updates `req`/`src_data` on the edge where it samples `ack`. The arbiter sees the updated `req` in the following IDLE.
- `fifo_full` is sampled only in IDLE. Because writes are at least 2 cycles apart, the FIFO's full flag has updated after the previous write by the time it is sampled.
- A GRANT is never cancelled by `fifo_full`.
- `rst_n` low during GRANT: the next cycle shows IDLE with `wr_en`=0 and `ack`=0. The pending word is dropped, and the source still holds `req`.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `LM_ERR_PRIORITY_EN` defined:
  - `req[0]` wins over all others whenever it is asserted.
  - The round-robin search covers indices 1 to `N_SRC`-1 only, and `last` tracks only those indices.
  - An error grant does not move `last`.
- `LM_ERR_PRIORITY_EN` undefined: all `N_SRC` sources share pure round-robin.

## Structure
- Shared package `lm_pkg` holds:
  - the state enum (IDLE, GRANT);
  - `N_SRC_DEF`, `STALL_MAX_DEF` and the source index constants `SRC_ERR`=0, `SRC_DATA`=1, `SRC_ACT`=2.
  - `WIDTH_LEDS` stays in the existing LM parameters.
- One sub-module, `lm_rr_select`: a combinational rotating-priority picker. Inputs are `req` and `last`; outputs are a one-hot grant and its index.

## Test plan
- Reset then `req`=3'b111, `fifo_full`=0, macro off → acks to sources 0, 1, 2, 0 on cycles 2, 4, 6, 8; `wr_data` matches each source's word.
- Single `req[1]` with data 8'hA5 → `wr_en`=1 and `wr_data`=8'hA5 exactly one cycle after the request; `ack`=3'b010 for one cycle.
- `fifo_full`=1 with `req[2]` high for 5 cycles, then released → no `wr_en` while full; grant 1 cycle after `fifo_full` falls.
- `STALL_MAX`=16, `fifo_full`=1, `req`≠0 held for 16 cycles → `stall`=1 from cycle 17. It stays high after `fifo_full` falls and clears only on reset.
- Macro on, `req`=3'b111 held → source 0 wins every round; after `req[0]` drops, sources 1 and 2 alternate.
- `rst_n` low during GRANT → next cycle `wr_en`=0, `ack`=0, `stall`=0; first post-reset grant goes to source 0.

Source files
------------

// File: rtl/lm_pkg.sv
// Shared LED-manager types and constants for the FIFO write-port arbiter.
package lm_pkg;

    localparam int WIDTH_LEDS    = 8;
    localparam int N_SRC_DEF     = 3;
    localparam int STALL_MAX_DEF = 1024;

    localparam int SRC_ERR  = 0;
    localparam int SRC_DATA = 1;
    localparam int SRC_ACT  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } lm_state_e;

endpackage

// File: rtl/lm_rr_select.sv
// Combinational rotating-priority picker: first asserted request after index last_i,
// in ascending order with wrap to 0.
module lm_rr_select #(
    parameter int N_SRC = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N_SRC; i++) begin
            j = (int'(last_i) + i) % N_SRC;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/lm_arbiter.sv
// Round-robin arbiter sharing the LED FIFO write port between error/data/actualization sources.
// Optional macro LM_ERR_PRIORITY_EN gives source 0 (error) fixed top priority.
module lm_arbiter
    import lm_pkg::*;
#(
    parameter int WIDTH     = WIDTH_LEDS,
    parameter int N_SRC     = N_SRC_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic                   fifo_full,
    output logic [N_SRC-1:0]       ack,
    output logic                   wr_en,
    output logic [WIDTH-1:0]       wr_data,
    output logic                   stall
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_SRC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_MAX);

    lm_state_e        state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, stall_d;

    logic [N_SRC-1:0] rr_req, rr_gnt, win_gnt;
    logic [IDX_W-1:0] rr_idx, win_idx, last_upd;
    logic             any_req;

    assign any_req = |req;

`ifdef LM_ERR_PRIORITY_EN
    // Error source is taken out of the ring; last only ever holds indices 1..N_SRC-1.
    assign rr_req = req & ~N_SRC'(1);

    always_comb begin
        if (req[SRC_ERR]) begin
            win_gnt  = N_SRC'(1);
            win_idx  = IDX_W'(SRC_ERR);
            last_upd = last_q;
        end else begin
            win_gnt  = rr_gnt;
            win_idx  = rr_idx;
            last_upd = rr_idx;
        end
    end
`else
    assign rr_req   = req;
    assign win_gnt  = rr_gnt;
    assign win_idx  = rr_idx;
    assign last_upd = rr_idx;
`endif

    lm_rr_select #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req_i  (rr_req),
        .last_i (last_q),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        ack_d     = '0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        case (state_q)
            IDLE: begin
                if (any_req && !fifo_full) begin
                    state_d   = GRANT;
                    ack_d     = win_gnt;
                    wr_en_d   = 1'b1;
                    wr_data_d = src_data[int'(win_idx)*WIDTH +: WIDTH];
                    last_d    = last_upd;
                    cnt_d     = '0;
                end else if (any_req) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            GRANT: state_d = IDLE;
        endcase
        if (cnt_d == CNT_MAX) stall_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= LAST_RST;
            ack_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
        end
    end

    assign ack     = ack_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign stall   = stall_q;

endmodule

// File: tb/tb_lm_arbiter.sv
// Self-checking bench for lm_arbiter: behavioural model plus directed literal expectations.
`timescale 1ns/1ps
module tb_lm_arbiter;

    localparam int W    = 8;
    localparam int N    = 3;
    localparam int SMAX = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] src_data;
    logic           fifo_full;
    logic [N-1:0]   ack;
    logic           wr_en;
    logic [W-1:0]   wr_data;
    logic           stall;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    bit         m_busy;
    int         m_last;
    int         m_cnt;
    logic [N-1:0] e_ack;
    logic       e_wr_en;
    logic [W-1:0] e_wr_data;
    logic       e_stall;

    lm_arbiter #(.WIDTH(W), .N_SRC(N), .STALL_MAX(SMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .src_data  (src_data),
        .fifo_full (fifo_full),
        .ack       (ack),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int lst);
`ifdef LM_ERR_PRIORITY_EN
        if (r[0]) return 0;
        for (int s = 1; s < N; s++) begin
            int c;
            c = 1 + ((lst - 1 + s) % (N - 1));
            if (r[c]) return c;
        end
`else
        for (int s = 1; s <= N; s++) begin
            int c;
            c = (lst + s) % N;
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_last = N - 1; m_cnt = 0;
            e_ack = '0; e_wr_en = 1'b0; e_wr_data = '0; e_stall = 1'b0;
        end else if (m_busy) begin
            m_busy = 0; e_ack = '0; e_wr_en = 1'b0;
        end else begin
            e_ack = '0; e_wr_en = 1'b0;
            if (req != 0 && !fifo_full) begin
                int w;
                w = pick(req, m_last);
                e_ack = N'(1) << w;
                e_wr_en = 1'b1;
                e_wr_data = src_data[w*W +: W];
                m_busy = 1;
                m_cnt = 0;
`ifdef LM_ERR_PRIORITY_EN
                if (w != 0) m_last = w;
`else
                m_last = w;
`endif
            end else if (req != 0) begin
                if (m_cnt < SMAX) m_cnt++;
            end else begin
                m_cnt = 0;
            end
            if (m_cnt == SMAX) e_stall = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ack", 32'(ack), 32'(e_ack));
            check("model_wr_en", 32'(wr_en), 32'(e_wr_en));
            check("model_wr_data", 32'(wr_data), 32'(e_wr_data));
            check("model_stall", 32'(stall), 32'(e_stall));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [N-1:0] exp_ack[4]  = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [W-1:0] exp_data[4] = '{8'h11, 8'h22, 8'h33, 8'h11};

    initial begin
        rst_n = 1'b0; req = '0; fifo_full = 1'b0;
        src_data = {8'h33, 8'h22, 8'h11};
        tick(); tick();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        chk_en = 1'b1;

        // round robin, all requesting
        rst_n = 1'b1; req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_ack", 32'(ack), 32'(exp_ack[i]));
            check("rr_data", 32'(wr_data), 32'(exp_data[i]));
            tick();
        end
        req = '0; tick();

        // single data request
        src_data[15:8] = 8'hA5; req = 3'b010;
        tick();
        check("single_wr_en", 32'(wr_en), 32'h1);
        check("single_data", 32'(wr_data), 32'hA5);
        check("single_ack", 32'(ack), 32'h2);
        req = '0; tick();
        check("single_ack_off", 32'(ack), 32'h0);
        check("single_wr_off", 32'(wr_en), 32'h0);

        // blocked by full FIFO, then released
        fifo_full = 1'b1; req = 3'b100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("full_no_wr", 32'(wr_en), 32'h0);
        end
        fifo_full = 1'b0; tick();
        check("full_rel_ack", 32'(ack), 32'h4);
        check("full_rel_wr", 32'(wr_en), 32'h1);
        req = '0; tick();

        // stall after SMAX blocked cycles
        fifo_full = 1'b1; req = 3'b001;
        for (int i = 1; i <= SMAX; i++) begin
            tick();
            if (i == SMAX - 1) check("stall_pre", 32'(stall), 32'h0);
            if (i == SMAX)     check("stall_set", 32'(stall), 32'h1);
        end
        fifo_full = 1'b0; tick();
        check("stall_grant", 32'(ack), 32'h1);
        req = '0; tick(); tick();
        check("stall_sticky", 32'(stall), 32'h1);

        // reset in GRANT
        req = 3'b010; tick();
        check("pre_rst_ack", 32'(ack), 32'h2);
        rst_n = 1'b0; tick();
        check("rst_g_wr_en", 32'(wr_en), 32'h0);
        check("rst_g_ack", 32'(ack), 32'h0);
        check("rst_g_stall", 32'(stall), 32'h0);
        rst_n = 1'b1; req = 3'b011; tick();
        check("post_rst_ack", 32'(ack), 32'h1);
        req = 3'b010; tick(); tick();
        check("post_rst_ack2", 32'(ack), 32'h2);
        req = '0; tick(); tick();

`ifdef LM_ERR_PRIORITY_EN
        begin
            logic [N-1:0] prev;
            req = 3'b111;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("prio_err", 32'(ack), 32'h1);
                tick();
            end
            req = 3'b110; prev = '0;
            for (int i = 0; i < 4; i++) begin
                tick();
                check("prio_alt", 32'((ack == 3'b010 || ack == 3'b100) && ack != prev), 32'h1);
                prev = ack;
                tick();
            end
            req = '0; tick();
        end
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
